spi_master_multi: RTL and testbench
===================================

Name: spi_master_multi

Overview:
Parametrised SPI master for PmodCLS-class peripherals and their successors. It supports configurable word width and SCLK divider, all four SPI modes (CPOL/CPHA) selected per transfer, MSB- or LSB-first order, and NUM_CS independent active-low chip selects. Chip select can be held asserted across back-to-back words for multi-byte commands. It sits between a command-sequencer FSM and the board pins, and is clocked by the 100 MHz system clock.

Parameters:
DATA_W, 8, bits per word (2..32)
CLK_DIV, 500, clk cycles per SCLK half-period (>=2); 500 gives 100 kHz SCLK
NUM_CS, 1, number of chip-select outputs (1..8)
CS_W, $clog2(NUM_CS) min 1, width of cs_sel

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  reset, synchronous, active-high
start  in  1  begin transfer; accepted in IDLE or HOLD only
tx_data  in  DATA_W  word to send, captured on accepted start
cs_sel  in  CS_W  chip select index, captured on start in IDLE
cpol  in  1  SCLK idle level, captured on start in IDLE
cpha  in  1  0: sample on leading edge; 1: sample on trailing edge
lsb_first  in  1  bit order, captured on every accepted start
hold_cs  in  1  1: keep CS asserted after this word (go to HOLD), captured on start
release  in  1  in HOLD: deassert CS and finish
busy  out  1  high in all states except IDLE
done  out  1  one-cycle pulse when rx_data is valid
rx_data  out  DATA_W  received word; stable until next done
sclk  out  1  SPI clock
mosi  out  1  serial data out
miso  in  1  serial data in
cs_n  out  NUM_CS  active-low chip selects

Behaviour:
- Reset: busy=0, done=0, rx_data=0, sclk=0, mosi=1, cs_n=all 1, state=IDLE, counters=0. Reset mid-transfer aborts on the same edge; no done is issued.
- States:
  - IDLE: start latches cs_sel, cpol, cpha, lsb_first, hold_cs and tx_data, then goes to SETUP.
  - SETUP: cs_n[cs_sel]=0. If cpha=0, mosi shows the first bit. Lasts CLK_DIV cycles, then goes to XFER.
  - XFER: runs 2*DATA_W half-periods. sclk toggles at the end of each half-period.
    - Leading edges are the odd toggles; trailing edges are the even toggles.
    - cpha=0: sample miso on leading edges; shift mosi on trailing edges, except after the last bit.
    - cpha=1: drive mosi on leading edges; sample on trailing edges.
    - The last toggle returns sclk to cpol. In that cycle rx_data is loaded and done=1.
    - Next state is HOLD if hold_cs=1, else RELEASE.
  - HOLD: CS stays low and sclk=cpol.
    - start: latch tx_data, lsb_first and hold_cs, then go to XFER with no SETUP. mosi is preloaded when cpha=0. cs_sel, cpol and cpha are unchanged.
    - release (without start): go to RELEASE.
    - start and release together: start wins; release is ignored.
  - RELEASE: cs_n all 1 and mosi=1. Lasts CLK_DIV cycles, then goes to IDLE.
- Latency: start accepted at cycle 0 gives done at cycle CLK_DIV + 2*DATA_W*CLK_DIV. busy falls CLK_DIV cycles after done when not holding.
- start in SETUP, XFER or RELEASE is ignored. release outside HOLD is ignored.
- cs_sel >= NUM_CS: the transfer runs normally but no cs_n line asserts.
- sclk in IDLE follows the cpol input. The cpol captured on start governs sclk from SETUP onward.
- The half-period counter counts 0..CLK_DIV-1 and wraps.
- The bit counter is $clog2(2*DATA_W)+1 bits wide and must not overflow at DATA_W=32.
- The receive shift register fills MSB-first or LSB-first per the latched lsb_first.

Decomposition:
- Package spi_pkg: state enumeration (IDLE, SETUP, XFER, HOLD, RELEASE), mode constants MODE0..MODE3 as {cpol,cpha}, and a clog2 helper function.
- Sub-module spi_clk_tick: half-period counter with enable and synchronous clear. Outputs a one-cycle tick every CLK_DIV cycles.

Test Plan:
1. DATA_W=8, CLK_DIV=2, mode 0, miso tied to mosi, tx 0xA5 -> rx_data=0xA5, done at cycle 34, 8 rising sclk edges, cs_n[0] low for 34 cycles, busy low at cycle 36.
2. All four modes with a slave model returning 0x3C while master sends 0xC3 -> rx_data=0x3C each time; sclk idle equals cpol; sample edge matches cpha.
3. lsb_first=1, tx 0x01 -> first mosi bit is 1 and the remaining seven are 0; a slave sending LSB-first 0x80 gives rx_data=0x80.
4. NUM_CS=4, hold_cs=1 words 0x11 and 0x22 on cs_sel=2, then release -> cs_n[2] low continuously, with no SETUP gap between words. Two done pulses; cs_n=4'hF CLK_DIV cycles after release. start and release pulsed together in HOLD -> third word sent.
5. start held high during XFER -> no re-trigger. rst asserted mid-word -> cs_n=all 1, mosi=1, busy=0 next cycle, no done pulse.
6. DATA_W=32, CLK_DIV=3, tx 0xDEADBEEF with loopback -> rx_data=0xDEADBEEF, done at cycle 195.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI master types: FSM states, SPI mode encodings and a constant clog2.
package spi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      XFER,
      HOLD,
      RELEASE
   } spi_state_t;

   // SPI modes encoded as {cpol, cpha}
   localparam logic [1:0] MODE0 = 2'b00;
   localparam logic [1:0] MODE1 = 2'b01;
   localparam logic [1:0] MODE2 = 2'b10;
   localparam logic [1:0] MODE3 = 2'b11;

   // Ceiling log2 usable in parameter and localparam expressions
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned res;
      res = 0;
      while ((64'd1 << res) < 64'(value)) res = res + 1;
      return res;
   endfunction

endpackage

// File: rtl/spi_clk_tick.sv
// Half-period timer: emits a one-cycle tick every CLK_DIV enabled cycles.
module spi_clk_tick
   import spi_pkg::*;
#(
   parameter int unsigned CLK_DIV = 500
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick_c
);

   localparam int unsigned CNT_W = clog2(CLK_DIV);

   logic [CNT_W-1:0] cnt;

   assign tick_c = en && !clr && (cnt == CNT_W'(CLK_DIV - 1));

   // Count 0..CLK_DIV-1 and wrap; clear has priority over counting
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tick_c ? '0 : cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/spi_master_multi.sv
// SPI master with per-transfer mode, bit order, chip-select hold and multiple chip selects.
module spi_master_multi
   import spi_pkg::*;
#(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned CLK_DIV = 500,
   parameter int unsigned NUM_CS  = 1,
   parameter int unsigned CS_W    = (clog2(NUM_CS) > 0) ? clog2(NUM_CS) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] tx_data,
   input  logic [CS_W-1:0]   cs_sel,
   input  logic              cpol,
   input  logic              cpha,
   input  logic              lsb_first,
   input  logic              hold_cs,
   input  logic              release_cs,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] rx_data,
   output logic              sclk,
   output logic              mosi,
   input  logic              miso,
   output logic [NUM_CS-1:0] cs_n
);

   localparam int unsigned     BC_W    = clog2(2 * DATA_W) + 1;
   localparam logic [BC_W-1:0] LAST_HP = BC_W'(2 * DATA_W - 1);

   spi_state_t        state, state_d;
   logic [DATA_W-1:0] tx_sh, tx_sh_d, rx_sh, rx_sh_d, rx_data_d;
   logic [BC_W-1:0]   hp, hp_d;
   logic              cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d, hold_q, hold_d;
   logic              busy_d, done_d, sclk_d, mosi_d;
   logic [NUM_CS-1:0] cs_n_d;
   logic              tick_en, tick_clr, tick_c;
   logic              load, leading, last;

   function automatic logic first_bit(input logic [DATA_W-1:0] v, input logic lsb);
      return lsb ? v[0] : v[DATA_W-1];
   endfunction

   function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] v, input logic lsb);
      return lsb ? (v >> 1) : (v << 1);
   endfunction

   assign tick_en  = (state == SETUP) || (state == XFER) || (state == RELEASE);
   assign tick_clr = !tick_en;

   spi_clk_tick #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .clk    (clk),
      .rst    (rst),
      .en     (tick_en),
      .clr    (tick_clr),
      .tick_c (tick_c)
   );

   // Next-state and next-output logic
   always_comb begin
      state_d   = state;
      tx_sh_d   = tx_sh;
      rx_sh_d   = rx_sh;
      rx_data_d = rx_data;
      hp_d      = hp;
      cpol_d    = cpol_q;
      cpha_d    = cpha_q;
      lsb_d     = lsb_q;
      hold_d    = hold_q;
      done_d    = 1'b0;
      sclk_d    = sclk;
      mosi_d    = mosi;
      cs_n_d    = cs_n;
      load      = 1'b0;
      leading   = 1'b0;
      last      = 1'b0;

      case (state)
         IDLE: begin
            sclk_d = cpol;
            mosi_d = 1'b1;
            cs_n_d = '1;
            if (start) begin
               state_d = SETUP;
               cpol_d  = cpol;
               cpha_d  = cpha;
               load    = 1'b1;
               for (int i = 0; i < NUM_CS; i++) cs_n_d[i] = (cs_sel != CS_W'(i));
            end
         end
         SETUP: begin
            if (tick_c) state_d = XFER;
         end
         XFER: begin
            if (tick_c) begin
               // toggle number hp+1: odd toggles are leading edges
               leading = !hp[0];
               last    = (hp == LAST_HP);
               sclk_d  = !sclk;
               hp_d    = hp + BC_W'(1);
               if (leading != cpha_q) begin
                  rx_sh_d = lsb_q ? {miso, rx_sh[DATA_W-1:1]} : {rx_sh[DATA_W-2:0], miso};
               end
               if (cpha_q ? leading : (!leading && !last)) begin
                  mosi_d  = first_bit(tx_sh, lsb_q);
                  tx_sh_d = shift_out(tx_sh, lsb_q);
               end
               if (last) begin
                  sclk_d    = cpol_q;
                  rx_data_d = rx_sh_d;
                  done_d    = 1'b1;
                  if (hold_q) begin
                     state_d = HOLD;
                  end else begin
                     state_d = RELEASE;
                     cs_n_d  = '1;
                     mosi_d  = 1'b1;
                  end
               end
            end
         end
         HOLD: begin
            sclk_d = cpol_q;
            if (start) begin
               state_d = XFER;
               load    = 1'b1;
            end else if (release_cs) begin
               state_d = RELEASE;
               cs_n_d  = '1;
               mosi_d  = 1'b1;
            end
         end
         RELEASE: begin
            cs_n_d = '1;
            mosi_d = 1'b1;
            if (tick_c) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Word capture shared by IDLE and HOLD starts; cpha=0 presents the first bit now
      if (load) begin
         lsb_d  = lsb_first;
         hold_d = hold_cs;
         hp_d   = '0;
         if (!cpha_d) begin
            mosi_d  = first_bit(tx_data, lsb_first);
            tx_sh_d = shift_out(tx_data, lsb_first);
         end else begin
            tx_sh_d = tx_data;
         end
      end

      busy_d = (state_d != IDLE);
   end

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         tx_sh   <= '0;
         rx_sh   <= '0;
         rx_data <= '0;
         hp      <= '0;
         cpol_q  <= 1'b0;
         cpha_q  <= 1'b0;
         lsb_q   <= 1'b0;
         hold_q  <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         sclk    <= 1'b0;
         mosi    <= 1'b1;
         cs_n    <= '1;
      end else begin
         state   <= state_d;
         tx_sh   <= tx_sh_d;
         rx_sh   <= rx_sh_d;
         rx_data <= rx_data_d;
         hp      <= hp_d;
         cpol_q  <= cpol_d;
         cpha_q  <= cpha_d;
         lsb_q   <= lsb_d;
         hold_q  <= hold_d;
         busy    <= busy_d;
         done    <= done_d;
         sclk    <= sclk_d;
         mosi    <= mosi_d;
         cs_n    <= cs_n_d;
      end
   end

endmodule

// File: tb/tb_spi_master_multi.sv
// Directed bench for spi_master_multi: 8-bit/4-CS instance and 32-bit/1-CS instance.
`timescale 1ns/1ps
module tb_spi_master_multi;
   import spi_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // 8-bit, CLK_DIV=2, NUM_CS=4 instance
   logic       start8 = 1'b0, cpol8 = 1'b0, cpha8 = 1'b0, lsb8 = 1'b0, hold8 = 1'b0, rel8 = 1'b0;
   logic [7:0] tx8 = 8'h00;
   logic [1:0] cs_sel8 = 2'd0;
   logic       busy8, done8, sclk8, mosi8, miso8;
   logic [7:0] rx8;
   logic [3:0] cs_n8;

   // 32-bit, CLK_DIV=3, NUM_CS=1 instance with loopback
   logic        start32 = 1'b0;
   logic [31:0] tx32 = 32'h0;
   logic [0:0]  cs_sel32 = 1'b0;
   logic        busy32, done32, sclk32, mosi32;
   logic [31:0] rx32;
   logic [0:0]  cs_n32;

   // Slave model / monitor state for the 8-bit instance
   logic       use_slave = 1'b0;
   logic       slave_lsb = 1'b0;
   logic [7:0] slave_word = 8'h00;
   logic       slave_miso;
   logic       tb_cpha = 1'b0;
   int         tcnt = 0;
   logic [7:0] rcv = 8'h00;
   logic       sclk_prev = 1'b0, mosi_prev = 1'b1, cs_prev = 1'b1;

   spi_master_multi #(.DATA_W(8), .CLK_DIV(2), .NUM_CS(4)) u_dut8 (
      .clk(clk), .rst(rst), .start(start8), .tx_data(tx8), .cs_sel(cs_sel8),
      .cpol(cpol8), .cpha(cpha8), .lsb_first(lsb8), .hold_cs(hold8), .release_cs(rel8),
      .busy(busy8), .done(done8), .rx_data(rx8), .sclk(sclk8), .mosi(mosi8),
      .miso(miso8), .cs_n(cs_n8)
   );

   spi_master_multi #(.DATA_W(32), .CLK_DIV(3), .NUM_CS(1)) u_dut32 (
      .clk(clk), .rst(rst), .start(start32), .tx_data(tx32), .cs_sel(cs_sel32),
      .cpol(1'b0), .cpha(1'b0), .lsb_first(1'b0), .hold_cs(1'b0), .release_cs(1'b0),
      .busy(busy32), .done(done32), .rx_data(rx32), .sclk(sclk32), .mosi(mosi32),
      .miso(mosi32), .cs_n(cs_n32)
   );

   assign miso8 = use_slave ? slave_miso : mosi8;

   // Slave output: bit index advances on the slave's drive edges
   always_comb begin
      int idx;
      if (tb_cpha) idx = (tcnt == 0) ? 0 : (tcnt - 1) / 2;
      else         idx = tcnt / 2;
      if (idx > 7)        slave_miso = 1'b0;
      else if (slave_lsb) slave_miso = slave_word[3'(idx)];
      else                slave_miso = slave_word[3'(7 - idx)];
   end

   // Count sclk toggles while cs_n[0] is low and capture mosi at sample edges (MSB-first arrival order)
   always @(negedge clk) begin
      if (cs_prev && !cs_n8[0]) begin
         tcnt = 0;
         rcv  = 8'h00;
      end else if (!cs_prev && (sclk8 !== sclk_prev)) begin
         tcnt = tcnt + 1;
         if (tcnt[0] ^ tb_cpha) rcv = {rcv[6:0], mosi_prev};
      end
      sclk_prev = sclk8;
      mosi_prev = mosi8;
      cs_prev   = cs_n8[0];
   end

   // Issue one word on the 8-bit instance and observe it until done (bounded)
   task automatic xfer8(input logic [7:0] tx, input logic [1:0] sel, input logic pol, input logic pha,
                        input logic lsb, input logic hold, input logic rel, input logic [3:0] cs_pat,
                        output int done_cyc, output logic [7:0] rx, output int rises,
                        output int cs_ok, output logic sclk_at_done);
      logic sclk_last;
      done_cyc = -1; rx = 8'h00; rises = 0; cs_ok = 0; sclk_at_done = 1'bx;
      @(negedge clk);
      tx8 = tx; cs_sel8 = sel; cpol8 = pol; cpha8 = pha; lsb8 = lsb; hold8 = hold; rel8 = rel;
      tb_cpha = pha; start8 = 1'b1;
      sclk_last = sclk8;
      for (int c = 0; c < 120; c++) begin
         @(negedge clk);
         start8 = 1'b0; rel8 = 1'b0;
         if (sclk8 && !sclk_last) rises++;
         sclk_last = sclk8;
         if (cs_n8 === cs_pat) cs_ok++;
         if (done8) begin
            done_cyc = c; rx = rx8; sclk_at_done = sclk8;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; cpol8 = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (busy8 !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy8); end
      checks++; if (done8 !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done8); end
      checks++; if (rx8 !== 8'h00) begin failures++; $display("FAIL reset_rx: got %h expected 00", rx8); end
      checks++; if (sclk8 !== 1'b0) begin failures++; $display("FAIL reset_sclk: got %b expected 0", sclk8); end
      checks++; if (mosi8 !== 1'b1) begin failures++; $display("FAIL reset_mosi: got %b expected 1", mosi8); end
      checks++; if (cs_n8 !== 4'hF) begin failures++; $display("FAIL reset_cs_n: got %h expected f", cs_n8); end
      checks++; if (rx32 !== 32'h0) begin failures++; $display("FAIL reset_rx32: got %h expected 0", rx32); end
      checks++; if (sclk32 !== 1'b0 || cs_n32 !== 1'b1 || busy32 !== 1'b0) begin
         failures++; $display("FAIL reset_dut32: got sclk=%b cs_n=%b busy=%b expected 0 1 0", sclk32, cs_n32, busy32);
      end
      rst = 1'b0; cpol8 = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_loopback_mode0;
      int dc, rises, csok; logic [7:0] rx; logic sat;
      use_slave = 1'b0;
      xfer8(8'hA5, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1110, dc, rx, rises, csok, sat);
      checks++; if (dc !== 34) begin failures++; $display("FAIL lb_done_cycle: got %0d expected 34", dc); end
      checks++; if (rx !== 8'hA5) begin failures++; $display("FAIL lb_rx: got %h expected a5", rx); end
      checks++; if (rises !== 8) begin failures++; $display("FAIL lb_rising_edges: got %0d expected 8", rises); end
      checks++; if (csok !== 34) begin failures++; $display("FAIL lb_cs_low_cycles: got %0d expected 34", csok); end
      @(negedge clk);
      checks++; if (busy8 !== 1'b1 || done8 !== 1'b0) begin
         failures++; $display("FAIL lb_cycle35: got busy=%b done=%b expected 1 0", busy8, done8);
      end
      checks++; if (rcv !== 8'hA5) begin failures++; $display("FAIL lb_mosi_bits: got %h expected a5", rcv); end
      @(negedge clk);
      checks++; if (busy8 !== 1'b0) begin failures++; $display("FAIL lb_busy_fall: got %b expected 0 at cycle 36", busy8); end
   endtask

   task automatic test_modes;
      logic [1:0] modes [4];
      int dc, rises, csok; logic [7:0] rx; logic sat; logic [1:0] md;
      modes = '{MODE0, MODE1, MODE2, MODE3};
      use_slave = 1'b1; slave_word = 8'h3C; slave_lsb = 1'b0;
      for (int m = 0; m < 4; m++) begin
         md = modes[m];
         cpol8 = md[1]; cpha8 = md[0]; tb_cpha = md[0];
         repeat (2) @(negedge clk);
         checks++; if (sclk8 !== md[1]) begin failures++; $display("FAIL mode%0d_idle_sclk: got %b expected %b", m, sclk8, md[1]); end
         xfer8(8'hC3, 2'd0, md[1], md[0], 1'b0, 1'b0, 1'b0, 4'b1110, dc, rx, rises, csok, sat);
         checks++; if (dc !== 34) begin failures++; $display("FAIL mode%0d_done_cycle: got %0d expected 34", m, dc); end
         checks++; if (rx !== 8'h3C) begin failures++; $display("FAIL mode%0d_rx: got %h expected 3c", m, rx); end
         checks++; if (sat !== md[1]) begin failures++; $display("FAIL mode%0d_sclk_at_done: got %b expected %b", m, sat, md[1]); end
         @(negedge clk);
         checks++; if (rcv !== 8'hC3) begin failures++; $display("FAIL mode%0d_slave_rx: got %h expected c3", m, rcv); end
         repeat (3) @(negedge clk);
      end
      cpol8 = 1'b0; cpha8 = 1'b0; tb_cpha = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_lsb_first;
      int dc, rises, csok; logic [7:0] rx; logic sat;
      use_slave = 1'b1; slave_word = 8'h80; slave_lsb = 1'b1;
      xfer8(8'h01, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1110, dc, rx, rises, csok, sat);
      checks++; if (dc !== 34) begin failures++; $display("FAIL lsb_done_cycle: got %0d expected 34", dc); end
      checks++; if (rx !== 8'h80) begin failures++; $display("FAIL lsb_rx: got %h expected 80", rx); end
      @(negedge clk);
      checks++; if (rcv !== 8'h80) begin failures++; $display("FAIL lsb_mosi_order: got %h expected 80 (1 then 0s)", rcv); end
      repeat (3) @(negedge clk);
      use_slave = 1'b0; slave_lsb = 1'b0;
   endtask

   task automatic test_hold_cs;
      int dc, rises, csok; logic [7:0] rx; logic sat;
      use_slave = 1'b0;
      xfer8(8'h11, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1011, dc, rx, rises, csok, sat);
      checks++; if (dc !== 34 || rx !== 8'h11) begin failures++; $display("FAIL hold_w1: got cyc=%0d rx=%h expected 34 11", dc, rx); end
      checks++; if (csok !== 35) begin failures++; $display("FAIL hold_w1_cs: got %0d expected 35", csok); end
      @(negedge clk);
      checks++; if (cs_n8 !== 4'b1011 || busy8 !== 1'b1) begin
         failures++; $display("FAIL hold_gap: got cs_n=%h busy=%b expected b 1", cs_n8, busy8);
      end
      xfer8(8'h22, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1011, dc, rx, rises, csok, sat);
      checks++; if (dc !== 32 || rx !== 8'h22) begin failures++; $display("FAIL hold_w2: got cyc=%0d rx=%h expected 32 22", dc, rx); end
      checks++; if (csok !== 33) begin failures++; $display("FAIL hold_w2_cs: got %0d expected 33", csok); end
      xfer8(8'h33, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1011, dc, rx, rises, csok, sat);
      checks++; if (dc !== 32 || rx !== 8'h33) begin failures++; $display("FAIL hold_start_wins: got cyc=%0d rx=%h expected 32 33", dc, rx); end
      @(negedge clk);
      rel8 = 1'b1;
      @(negedge clk);
      rel8 = 1'b0;
      checks++; if (busy8 !== 1'b1) begin failures++; $display("FAIL release_busy: got %b expected 1", busy8); end
      repeat (2) @(negedge clk);
      checks++; if (cs_n8 !== 4'hF || busy8 !== 1'b0) begin
         failures++; $display("FAIL release_end: got cs_n=%h busy=%b expected f 0", cs_n8, busy8);
      end
      hold8 = 1'b0; cs_sel8 = 2'd0;
   endtask

   task automatic test_start_held_and_abort;
      int ndone, dc; logic [7:0] rx;
      use_slave = 1'b0; ndone = 0; dc = -1; rx = 8'h00;
      @(negedge clk);
      tx8 = 8'h5A; cs_sel8 = 2'd0; cpol8 = 1'b0; cpha8 = 1'b0; lsb8 = 1'b0; hold8 = 1'b0; tb_cpha = 1'b0;
      start8 = 1'b1;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (c == 5) tx8 = 8'hFF;
         if (c == 30) start8 = 1'b0;
         if (done8) begin
            ndone++;
            if (dc < 0) begin dc = c; rx = rx8; end
         end
      end
      checks++; if (ndone !== 1) begin failures++; $display("FAIL held_start_dones: got %0d expected 1", ndone); end
      checks++; if (dc !== 34 || rx !== 8'h5A) begin failures++; $display("FAIL held_start_word: got cyc=%0d rx=%h expected 34 5a", dc, rx); end

      @(negedge clk);
      tx8 = 8'h96; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (8) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++; if (cs_n8 !== 4'hF || mosi8 !== 1'b1) begin
         failures++; $display("FAIL abort_pins: got cs_n=%h mosi=%b expected f 1", cs_n8, mosi8);
      end
      checks++; if (busy8 !== 1'b0 || done8 !== 1'b0) begin
         failures++; $display("FAIL abort_status: got busy=%b done=%b expected 0 0", busy8, done8);
      end
      rst = 1'b0;
      ndone = 0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (done8) ndone++;
      end
      checks++; if (ndone !== 0) begin failures++; $display("FAIL abort_no_done: got %0d expected 0", ndone); end
   endtask

   task automatic test_wide_word;
      int dc, bf, csl; logic [31:0] rx;
      for (int run = 0; run < 2; run++) begin
         dc = -1; bf = -1; csl = 0; rx = 32'h0;
         @(negedge clk);
         tx32 = (run == 0) ? 32'hDEADBEEF : 32'h13579BDF;
         cs_sel32 = (run == 0) ? 1'b0 : 1'b1;
         start32 = 1'b1;
         for (int c = 0; c < 210; c++) begin
            @(negedge clk);
            start32 = 1'b0;
            if (!cs_n32[0]) csl++;
            if (done32 && dc < 0) begin dc = c; rx = rx32; end
            if (!busy32 && bf < 0) bf = c;
         end
         checks++; if (dc !== 195) begin failures++; $display("FAIL wide%0d_done_cycle: got %0d expected 195", run, dc); end
         checks++; if (rx !== ((run == 0) ? 32'hDEADBEEF : 32'h13579BDF)) begin
            failures++; $display("FAIL wide%0d_rx: got %h", run, rx);
         end
         checks++; if (bf !== 198) begin failures++; $display("FAIL wide%0d_busy_fall: got %0d expected 198", run, bf); end
         checks++; if (csl !== ((run == 0) ? 195 : 0)) begin
            failures++; $display("FAIL wide%0d_cs_low_cycles: got %0d expected %0d", run, csl, (run == 0) ? 195 : 0);
         end
      end
   endtask

   initial begin
      test_reset();
      test_loopback_mode0();
      test_modes();
      test_lsb_first();
      test_hold_cs();
      test_start_held_and_abort();
      test_wide_word();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
